// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: pipeline control and instruction-memory handshake bundle for ifetch_unit.
interface ifetch_unit_if #(parameter int XLEN = 64);
  logic pc_valid, stall, flush, imem_ready, imem_valid, imem_err;
  logic imem_req, instr_valid;
  logic [XLEN-1:0] pc_next, imem_data, pc_current;
  logic [31:0] imem_addr, instruction;
  modport master (
    input pc_valid, stall, flush, pc_next, imem_ready, imem_valid, imem_err, imem_data,
    output imem_req, imem_addr, instruction, instr_valid, pc_current
  );
  modport slave (
    output pc_valid, stall, flush, pc_next, imem_ready, imem_valid, imem_err, imem_data,
    input imem_req, imem_addr, instruction, instr_valid, pc_current
  );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding instruction fetch with stall/flush control.
// Define IFETCH_RESP_BYPASS_EN to let a response accepted together with the request skip WAIT.
module ifetch_unit #(parameter int XLEN = 64) (
  input logic clk,
  input logic resetn,
  ifetch_unit_if.master bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, REQ = 3'd1, WAIT = 3'd2, RESP = 3'd3, DRAIN = 3'd4} state_t;
  state_t r_state, w_next;
  logic [31:0] r_instr, r_addr, w_word;
  logic [XLEN-1:0] r_pc, w_shift;
  logic w_done, w_issue, w_capture;
  assign w_done = bus.imem_valid | bus.imem_err;
  assign w_shift = bus.imem_data >> {(XLEN == 64) && r_addr[2], 5'd0};
  assign w_word = w_shift[31:0];
  assign w_issue = r_state == IDLE && w_next == REQ;
  assign w_capture = w_next == RESP && r_state != RESP;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = (bus.pc_valid && !bus.stall && !bus.flush) ? REQ : IDLE;
      REQ: begin
        w_next = bus.flush ? (bus.imem_ready ? DRAIN : IDLE) : (bus.imem_ready ? WAIT : REQ);
`ifdef IFETCH_RESP_BYPASS_EN
        if (bus.imem_ready && w_done) w_next = (bus.flush || bus.imem_err) ? IDLE : RESP;
`else
`endif
      end
      WAIT: w_next = (bus.imem_err || (bus.flush && bus.imem_valid)) ? IDLE :
                     bus.flush ? DRAIN : bus.imem_valid ? RESP : WAIT;
      RESP: w_next = (bus.stall && !bus.flush) ? RESP : IDLE;
      DRAIN: w_next = w_done ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state <= IDLE;
      r_instr <= '0;
      r_addr <= '0;
      r_pc <= '0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_pc <= bus.pc_next;
        r_addr <= bus.pc_next[31:0];
      end
      if (w_capture) r_instr <= w_word;
    end
  end
  assign bus.imem_req = r_state == REQ;
  assign bus.instr_valid = r_state == RESP;
  assign bus.instruction = r_instr;
  assign bus.imem_addr = r_addr;
  assign bus.pc_current = r_pc;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed and randomized fetch transactions checked against transaction-level expectations.
module tb_ifetch_unit;
  localparam int XLEN = 64;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  int errors = 0, checks = 0, cyc = 0;
  logic [31:0] exp_instr = '0;
  ifetch_unit_if #(.XLEN(XLEN)) bus ();
  ifetch_unit #(.XLEN(XLEN)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, bus.imem_req, 0);
    chk({tag, "_iv"}, bus.instr_valid, 0);
    chk({tag, "_instr"}, bus.instruction, 0);
    chk({tag, "_addr"}, bus.imem_addr, 0);
    chk({tag, "_pc"}, bus.pc_current, 0);
  endtask
  function automatic logic [31:0] sel(input logic [63:0] pc, input logic [63:0] data);
    return pc[2] ? data[63:32] : data[31:0];
  endfunction
  // Called and returns at a negedge with the DUT idle.
  task automatic fetch(input logic [63:0] pc, input logic [63:0] data, input int rd, input int vd,
                       input int sd, input bit err);
    int t0;
    t0 = cyc;
    bus.pc_valid = 1; bus.pc_next = pc; bus.imem_ready = 0;
    @(negedge clk);
    bus.pc_valid = 0;
    chk("req", bus.imem_req, 1);
    chk("addr", bus.imem_addr, pc[31:0]);
    chk("pc", bus.pc_current, pc);
    chk("iv_req", bus.instr_valid, 0);
    for (int i = 0; i < rd; i++) begin
      bus.imem_valid = 1'($urandom);
      @(negedge clk);
      chk("req_held", bus.imem_req, 1);
      chk("addr_held", bus.imem_addr, pc[31:0]);
    end
    bus.imem_valid = 0; bus.imem_ready = 1;
    @(negedge clk);
    bus.imem_ready = 0;
    chk("req_wait", bus.imem_req, 0);
    chk("iv_wait", bus.instr_valid, 0);
    for (int i = 0; i < vd; i++) begin
      @(negedge clk);
      chk("iv_wait2", bus.instr_valid, 0);
    end
    bus.imem_data = data;
    if (err) begin bus.imem_err = 1; bus.imem_valid = 1'($urandom); end
    else bus.imem_valid = 1;
    @(negedge clk);
    bus.imem_valid = 0; bus.imem_err = 0; bus.imem_data = {$urandom, $urandom};
    if (err) begin
      chk("err_iv", bus.instr_valid, 0);
      chk("err_instr", bus.instruction, exp_instr);
      chk("err_req", bus.imem_req, 0);
      return;
    end
    exp_instr = sel(pc, data);
    chk("iv", bus.instr_valid, 1);
    chk("instr", bus.instruction, exp_instr);
    chk("pc_resp", bus.pc_current, pc);
    chk("lat", 64'(cyc - t0), 64'(3 + rd + vd));
    for (int i = 0; i < sd; i++) begin
      bus.stall = 1;
      @(negedge clk);
      chk("stall_iv", bus.instr_valid, 1);
      chk("stall_instr", bus.instruction, exp_instr);
    end
    bus.stall = 0;
    @(negedge clk);
    chk("iv_end", bus.instr_valid, 0);
    chk("req_end", bus.imem_req, 0);
  endtask
  task automatic flush_wait(input logic [63:0] pc, input int dly, input bit hit);
    bus.pc_valid = 1; bus.pc_next = pc; bus.imem_ready = 1;
    @(negedge clk);
    bus.pc_valid = 0;
    chk("fw_req", bus.imem_req, 1);
    @(negedge clk);
    bus.imem_ready = 0; bus.flush = 1; bus.imem_valid = hit; bus.imem_data = {$urandom, $urandom};
    @(negedge clk);
    bus.flush = 0; bus.imem_valid = 0;
    chk("fw_iv", bus.instr_valid, 0);
    chk("fw_instr", bus.instruction, exp_instr);
    if (hit) return;
    for (int i = 0; i < dly; i++) begin
      bus.pc_valid = 1; bus.pc_next = pc ^ 64'h100; bus.flush = 1'($urandom);
      @(negedge clk);
      chk("drain_req", bus.imem_req, 0);
      chk("drain_pc", bus.pc_current, pc);
    end
    bus.pc_valid = 0; bus.flush = 0; bus.imem_valid = 1; bus.imem_data = {$urandom, $urandom};
    @(negedge clk);
    bus.imem_valid = 0;
    chk("drain_iv", bus.instr_valid, 0);
    chk("drain_instr", bus.instruction, exp_instr);
    chk("drain_req2", bus.imem_req, 0);
  endtask
  task automatic flush_req(input logic [63:0] pc);
    bus.pc_valid = 1; bus.pc_next = pc; bus.imem_ready = 0;
    @(negedge clk);
    bus.pc_valid = 0; bus.flush = 1;
    @(negedge clk);
    bus.flush = 0;
    chk("fr_req", bus.imem_req, 0);
    chk("fr_pc", bus.pc_current, pc);
  endtask
  initial begin
    int t0;
    logic [63:0] d;
    bus.pc_valid = 0; bus.stall = 0; bus.flush = 0; bus.pc_next = '0;
    bus.imem_ready = 0; bus.imem_valid = 0; bus.imem_err = 0; bus.imem_data = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    resetn = 0;
    @(negedge clk);
    chk_zero("post_rst");
    d = 64'h0072_6168_756C_2121;
    t0 = cyc;
    fetch(64'h8000_0000, d, 0, 0, 0, 0);
    chk("basic_instr", bus.instruction, 32'h756C2121);
    fetch(64'h8000_0000, d, 0, 0, 0, 0);
    chk("throughput", 64'(cyc - t0), 64'd8);
    fetch(64'h8000_0004, d, 0, 0, 0, 0);
    chk("upper_instr", bus.instruction, 32'h00726168);
    fetch(64'h8000_0008, 64'h1111_2222_3333_4444, 3, 0, 2, 0);
    fetch(64'h8000_000C, 64'hDEAD_BEEF_0BAD_F00D, 0, 1, 0, 1);
    flush_wait(64'h8000_0010, 2, 0);
    flush_wait(64'h8000_0014, 0, 1);
    flush_req(64'h8000_0018);
    fetch(64'h8000_001C, 64'hCAFE_0001_CAFE_0002, 0, 0, 0, 0);
    // Response offered together with request acceptance.
    bus.pc_valid = 1; bus.pc_next = 64'h20;
    @(negedge clk);
    bus.pc_valid = 0; bus.imem_ready = 1; bus.imem_valid = 1; bus.imem_data = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    bus.imem_ready = 0; bus.imem_valid = 0;
`ifdef IFETCH_RESP_BYPASS_EN
    exp_instr = 32'h89ABCDEF;
    chk("byp_iv", bus.instr_valid, 1);
    chk("byp_instr", bus.instruction, exp_instr);
    @(negedge clk);
    chk("byp_end", bus.instr_valid, 0);
`else
    chk("nobyp_iv", bus.instr_valid, 0);
    bus.imem_valid = 1;
    @(negedge clk);
    bus.imem_valid = 0;
    exp_instr = 32'h89ABCDEF;
    chk("nobyp_iv2", bus.instr_valid, 1);
    chk("nobyp_instr", bus.instruction, exp_instr);
    @(negedge clk);
    chk("nobyp_end", bus.instr_valid, 0);
`endif
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        bus.pc_valid = 1'($urandom); bus.pc_next = {$urandom, $urandom};
        if (bus.pc_valid) begin
          if ($urandom % 2) bus.stall = 1; else bus.flush = 1;
        end
        @(negedge clk);
        bus.pc_valid = 0; bus.stall = 0; bus.flush = 0;
        chk("idle_req", bus.imem_req, 0);
      end
      case ($urandom % 8)
        0: flush_wait({$urandom, $urandom}, $urandom_range(0, 3), 1'($urandom));
        1: flush_req({$urandom, $urandom});
        default: fetch({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 2), ($urandom % 6) == 0);
      endcase
    end
    // Asynchronous reset while a request is outstanding.
    bus.pc_valid = 1; bus.pc_next = 64'hFFFF_FFFF_FFFF_FFF4;
    @(negedge clk);
    bus.pc_valid = 0;
    #2 resetn = 1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    resetn = 0;
    exp_instr = '0;
    fetch(64'h8000_0004, d, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage of the RISC-V core. It accepts a next-PC from the PC/branch logic and issues one request at a time on the instruction-memory handshake. It extracts the 32-bit instruction from the returned XLEN-wide data word and presents it with a valid flag to decode. Stall and flush inputs from the pipeline control it.

## Interface
- XLEN, default 64: architectural width of PC and memory data; legal values 32 or 64.

- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous reset, active-high (asserted = 1), despite the name.
- pc_valid  in  1  pc_next holds a PC to fetch.
- stall  in  1  downstream cannot accept; blocks new requests and holds the delivered instruction.
- flush  in  1  discard any fetch in progress.
- pc_next  in  XLEN  PC to fetch.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_valid  in  1  response data valid this cycle.
- imem_err  in  1  response is an error; has priority over imem_valid.
- imem_data  in  XLEN  response data word.
- imem_req  out  1  request valid (registered).
- imem_addr  out  32  request byte address, pc_next[31:0] latched at issue.
- instruction  out  32  fetched instruction.
- instr_valid  out  1  instruction valid for decode.
- pc_current  out  XLEN  PC of the fetch in flight or delivered.

## Operation
- States and encoding: IDLE=0, REQ=1, WAIT=2, RESP=3, DRAIN=4.
- Outputs are decoded from state: imem_req=1 only in REQ; instr_valid=1 only in RESP.
- IDLE, pc_valid && !stall && !flush:
  - latch pc_current<=pc_next and imem_addr<=pc_next[31:0];
  - go to REQ.
- REQ, imem_ready: go to WAIT. Otherwise stay in REQ with the address held.
- WAIT:
  - imem_err: go to IDLE; instruction is unchanged and instr_valid never rises.
  - else imem_valid: capture instruction and go to RESP.
- Word select:
  - XLEN=64: imem_addr[2] ? imem_data[63:32] : imem_data[31:0].
  - XLEN=32: imem_data[31:0].
- RESP:
  - stall: stay in RESP; instruction and instr_valid are held.
  - otherwise go to IDLE.
- Flush has priority over all other transitions:
  - IDLE or RESP: go to IDLE.
  - REQ without imem_ready: go to IDLE.
  - REQ with imem_ready in the same cycle: the request was accepted, so go to DRAIN.
  - WAIT: go to DRAIN, unless imem_valid or imem_err arrives the same cycle; then go to IDLE and discard the data.
- DRAIN: wait for imem_valid || imem_err, discard it, go to IDLE. Flush while in DRAIN stays in DRAIN.
- Misaligned PCs are fetched unchanged; no alignment trap in this block.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE;
  - imem_req=0, instr_valid=0;
  - instruction=0, imem_addr=0, pc_current=0.
- Base latency, with ready and valid immediate: pc_valid sampled at edge N.
  - imem_req=1 after N.
  - WAIT after N+1.
  - instr_valid=1 after N+2 for one cycle.
  - IDLE after N+3.
  - Throughput is one fetch per 4 cycles.
- Each extra cycle of imem_ready low, imem_valid low, or stall in RESP adds one cycle.
- At most one outstanding request.

## Configuration
- IFETCH_RESP_BYPASS_EN defined:
  - in REQ, imem_ready && imem_valid in the same cycle captures data and goes directly to RESP, skipping WAIT;
  - imem_ready && imem_err goes directly to IDLE;
  - latency drops to 3 cycles per fetch.
- IFETCH_RESP_BYPASS_EN undefined: REQ always passes through WAIT, and imem_valid is ignored in REQ.

## Test plan
- Reset: hold resetn=1 for 5 cycles, then release with pc_valid=0 -> all outputs 0, state IDLE.
- Basic fetch:
  - stimulus: XLEN=64, pc_next=0x8000_0000, imem_ready=imem_valid=1, imem_data=0x0072_6168_756C_2121;
  - response: imem_req high 1 cycle, imem_addr=0x8000_0000, instruction=0x756C2121, instr_valid pulses, pc_current=0x8000_0000;
  - repeats every 4 cycles.
- Upper word: pc_next=0x8000_0004, same data -> instruction=0x00726168.
- Backpressure: imem_ready=0 for 3 cycles -> imem_req held with stable imem_addr. Then stall=1 during RESP for 2 cycles -> instr_valid and instruction held.
- Error: imem_err=1 with imem_valid=1 in WAIT -> instr_valid stays 0, state returns to IDLE, instruction unchanged.
- Flush in WAIT with imem_valid=0:
  - DRAIN entered;
  - later imem_valid=1 is discarded, instr_valid stays 0;
  - IDLE follows.
- Repeat the basic fetch with IFETCH_RESP_BYPASS_EN defined -> 3 cycles per fetch.
